// File: rtl/mc_pc_sequencer.sv
// mc_pc_sequencer
// Multi-cycle control sequencer that drives the program-counter register.
// Each instruction walks IF -> ID -> (EXE/MEM/WB) and the PC write enable
// fires exactly once, in the instruction's final state. The next PC and the
// datapath write strobes are combinational from the current state and the
// opcode held in the instruction register, so the PC (which samples on the
// falling edge) picks up the value within the same cycle.
module mc_pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        sign,
  input  logic [31:0] pc,
  input  logic [31:0] imm_ext,
  input  logic [25:0] jaddr,
  input  logic [31:0] rs_data,
  output logic [2:0]  state,
  output logic        ir_wre,
  output logic        reg_wre,
  output logic        mem_wr,
  output logic        pc_wre,
  output logic [31:0] next_pc,
  output logic        halted,
  output logic        illegal
);

  // The PC register is loaded with word addresses; a misaligned reset PC is
  // a configuration error caught at elaboration.
  generate
    if (RESET_PC[1:0] != 2'b00) begin : g_reset_pc_check
      $error("mc_pc_sequencer: RESET_PC must be word aligned");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  typedef enum logic [2:0] {
    C_ALU  = 3'd0,
    C_SW   = 3'd1,
    C_LW   = 3'd2,
    C_BR   = 3'd3,
    C_JMP  = 3'd4,
    C_HALT = 3'd5,
    C_ILL  = 3'd6
  } op_class_t;

  localparam logic [5:0] OP_BEQ  = 6'b110000;
  localparam logic [5:0] OP_BNE  = 6'b110001;
  localparam logic [5:0] OP_BLTZ = 6'b110010;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;

  state_t    state_q, state_d;
  logic      halted_q, halted_d;
  logic      illegal_q, illegal_d;
  op_class_t cls;
  logic [31:0] pc_plus4;

  // Opcode decode into the instruction classes that drive sequencing.
  function automatic op_class_t op_class(input logic [5:0] op);
    case (op)
      6'b000000, 6'b000001, 6'b000010,
      6'b010000, 6'b010001, 6'b010010,
      6'b011000:                         op_class = C_ALU;
      6'b100110:                         op_class = C_SW;
      6'b100111:                         op_class = C_LW;
      6'b110000, 6'b110001, 6'b110010:   op_class = C_BR;
      6'b111000, 6'b111001, 6'b111010:   op_class = C_JMP;
      6'b111111:                         op_class = C_HALT;
      default:                           op_class = C_ILL;
    endcase
  endfunction

  // Branch condition from the ALU flags; anything else is not taken.
  function automatic logic br_taken(input logic [5:0] op, input logic z,
                                    input logic s);
    case (op)
      OP_BEQ:  br_taken = z;
      OP_BNE:  br_taken = ~z;
      OP_BLTZ: br_taken = s;
      default: br_taken = 1'b0;
    endcase
  endfunction

  // Taken-branch target: word offset is the signed immediate scaled by 4,
  // added to the sequential PC with plain 32-bit wrap-around.
  function automatic logic [31:0] br_target(input logic [31:0] seq_pc,
                                            input logic [31:0] imm);
    logic signed [31:0] off;
    off = signed'(imm) <<< 2;
    br_target = seq_pc + unsigned'(off);
  endfunction

  // Jump target: j/jal splice the target field into the sequential PC's
  // region bits, jr takes the register value exactly as read.
  function automatic logic [31:0] jmp_target(input logic [5:0] op,
                                             input logic [31:0] seq_pc,
                                             input logic [25:0] ja,
                                             input logic [31:0] rs);
    if (op == OP_JR) jmp_target = rs;
    else             jmp_target = {seq_pc[31:28], ja, 2'b00};
  endfunction

  assign cls      = op_class(opcode);
  assign pc_plus4 = pc + 32'd4;

  // State register: reset returns to IF and clears the halt and illegal flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IF;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic; HALT parks in the ID encoding until reset.
  always_comb begin
    state_d   = state_q;
    halted_d  = halted_q;
    illegal_d = 1'b0;
    if (!halted_q) begin
      case (state_q)
        S_IF: state_d = S_ID;
        S_ID: begin
          case (cls)
            C_ALU:       state_d = S_EXE_AL;
            C_SW, C_LW:  state_d = S_EXE_LS;
            C_BR:        state_d = S_EXE_BR;
            C_JMP:       state_d = S_IF;
            C_HALT: begin
              state_d  = S_ID;
              halted_d = 1'b1;
            end
            default: begin
              state_d   = S_IF;
              illegal_d = 1'b1;
            end
          endcase
        end
        S_EXE_AL: state_d = S_WB_AL;
        S_WB_AL:  state_d = S_IF;
        S_EXE_LS: state_d = S_MEM;
        S_MEM:    state_d = (cls == C_LW) ? S_WB_LD : S_IF;
        S_WB_LD:  state_d = S_IF;
        S_EXE_BR: state_d = S_IF;
        default:  state_d = S_IF;
      endcase
    end
  end

  // Output logic: strobes are forced low while reset is asserted so a reset
  // mid-instruction never commits a PC or register write.
  always_comb begin
    ir_wre  = 1'b0;
    reg_wre = 1'b0;
    mem_wr  = 1'b0;
    pc_wre  = 1'b0;
    next_pc = pc_plus4;
    if (!halted_q) begin
      case (state_q)
        S_IF: ir_wre = 1'b1;
        S_ID: begin
          if (cls == C_JMP) begin
            next_pc = jmp_target(opcode, pc_plus4, jaddr, rs_data);
            pc_wre  = 1'b1;
            reg_wre = (opcode == OP_JAL);
          end else if (cls == C_ILL) begin
            pc_wre = 1'b1;
          end
        end
        S_MEM: begin
          if (cls != C_LW) begin
            mem_wr = (cls == C_SW);
            pc_wre = 1'b1;
          end
        end
        S_WB_LD, S_WB_AL: begin
          reg_wre = 1'b1;
          pc_wre  = 1'b1;
        end
        S_EXE_BR: begin
          pc_wre = 1'b1;
          if (br_taken(opcode, zero, sign)) next_pc = br_target(pc_plus4, imm_ext);
        end
        default: ;
      endcase
    end
    if (reset) begin
      ir_wre  = 1'b0;
      reg_wre = 1'b0;
      mem_wr  = 1'b0;
      pc_wre  = 1'b0;
    end
  end

  assign state   = state_q;
  assign halted  = halted_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_mc_pc_sequencer.sv
// Testbench for mc_pc_sequencer: per-instruction reference model pushes the
// expected per-cycle outputs into a queue; a monitor pops and compares them
// on every falling edge.
module tb_mc_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode = '0;
  logic        zero = 1'b0;
  logic        sign = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] imm_ext = '0;
  logic [25:0] jaddr = '0;
  logic [31:0] rs_data = '0;
  logic [2:0]  state;
  logic        ir_wre, reg_wre, mem_wr, pc_wre, halted, illegal;
  logic [31:0] next_pc;

  mc_pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .sign(sign),
    .pc(pc), .imm_ext(imm_ext), .jaddr(jaddr), .rs_data(rs_data),
    .state(state), .ir_wre(ir_wre), .reg_wre(reg_wre), .mem_wr(mem_wr),
    .pc_wre(pc_wre), .next_pc(next_pc), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [2:0]  st;
    logic        ir, rg, mw, pw;
    logic [31:0] np;
    logic        hl, il;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  logic ill_pend = 1'b0;

  localparam int K_ALU = 0, K_SW = 1, K_LW = 2, K_BR = 3, K_JMP = 4, K_HALT = 5, K_ILL = 6;

  logic [5:0] legal_ops [16] = '{6'b000000, 6'b000001, 6'b000010, 6'b010000,
                                 6'b010001, 6'b010010, 6'b011000, 6'b100110,
                                 6'b100111, 6'b110000, 6'b110001, 6'b110010,
                                 6'b111000, 6'b111001, 6'b111010, 6'b111111};

  function automatic int classify(input logic [5:0] op);
    if (op inside {6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
                   6'b010010, 6'b011000}) return K_ALU;
    if (op == 6'b100110) return K_SW;
    if (op == 6'b100111) return K_LW;
    if (op inside {6'b110000, 6'b110001, 6'b110010}) return K_BR;
    if (op inside {6'b111000, 6'b111001, 6'b111010}) return K_JMP;
    if (op == 6'b111111) return K_HALT;
    return K_ILL;
  endfunction

  // Monitor: one expected record per cycle, compared mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        exp_t e;
        logic [40:0] act, want;
        e = q.pop_front();
        act  = {state, ir_wre, reg_wre, mem_wr, pc_wre, next_pc, halted, illegal};
        want = {e.st, e.ir, e.rg, e.mw, e.pw, e.np, e.hl, e.il};
        total++;
        if (act !== want) begin
          bad++;
          $display("FAIL %s t=%0t: got st=%0d ir=%b rg=%b mw=%b pw=%b np=%h hl=%b il=%b, want st=%0d ir=%b rg=%b mw=%b pw=%b np=%h hl=%b il=%b",
                   e.nm, $time, state, ir_wre, reg_wre, mem_wr, pc_wre, next_pc, halted, illegal,
                   e.st, e.ir, e.rg, e.mw, e.pw, e.np, e.hl, e.il);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string nm, input logic [2:0] st, input logic ir,
                      input logic rg, input logic mw, input logic pw,
                      input logic [31:0] np, input logic hl, input logic il);
    exp_t e;
    e.nm = nm; e.st = st; e.ir = ir; e.rg = rg; e.mw = mw; e.pw = pw;
    e.np = np; e.hl = hl; e.il = il;
    q.push_back(e);
  endtask

  // Hold reset for n cycles; after the first reset edge the sequencer must
  // sit in IF with every strobe low.
  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i > 0) push("reset_state", 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, pc + 32'd4, 1'b0, 1'b0);
      next_cycle();
    end
    reset = 1'b0;
    ill_pend = 1'b0;
  endtask

  // Run one instruction starting in its IF cycle. abort_at >= 0 asserts
  // reset during that cycle of the instruction.
  task automatic run_instr(input string nm, input logic [5:0] op,
                           input logic [31:0] pcv, input logic [31:0] immv,
                           input logic z, input logic s, input logic [25:0] ja,
                           input logic [31:0] rs, input int abort_at);
    int kind, n;
    logic [2:0] seq [5];
    logic [31:0] p4, fin;
    logic taken;
    opcode = op; pc = pcv; imm_ext = immv; zero = z; sign = s;
    jaddr = ja; rs_data = rs;
    kind = classify(op);
    p4 = pcv + 32'd4;
    fin = p4;
    seq = '{3'd0, 3'd1, 3'd0, 3'd0, 3'd0};
    case (kind)
      K_ALU: begin n = 4; seq[2] = 3'd6; seq[3] = 3'd7; end
      K_SW:  begin n = 4; seq[2] = 3'd2; seq[3] = 3'd3; end
      K_LW:  begin n = 5; seq[2] = 3'd2; seq[3] = 3'd3; seq[4] = 3'd4; end
      K_BR: begin
        n = 3; seq[2] = 3'd5;
        taken = (op == 6'b110000 && z) || (op == 6'b110001 && !z) || (op == 6'b110010 && s);
        if (taken) fin = p4 + (immv << 2);
      end
      K_JMP: begin
        n = 2;
        if (op == 6'b111001) fin = rs;
        else fin = {p4[31:28], ja, 2'b00};
      end
      default: n = 2;
    endcase
    for (int k = 0; k < n; k++) begin
      logic ab, last;
      ab = (k == abort_at);
      last = (k == n - 1);
      if (ab) reset = 1'b1;
      push(nm, seq[k],
           !ab && k == 0,
           !ab && ((last && (kind == K_ALU || kind == K_LW)) || (k == 1 && op == 6'b111010)),
           !ab && last && kind == K_SW,
           !ab && last && kind != K_HALT,
           last ? fin : p4,
           1'b0,
           (k == 0) ? ill_pend : 1'b0);
      next_cycle();
      if (ab) begin
        reset = 1'b0;
        ill_pend = 1'b0;
        return;
      end
    end
    ill_pend = (kind == K_ILL);
    if (kind == K_HALT) begin
      for (int h = 0; h < 22; h++) begin
        opcode = 6'($urandom);
        zero = 1'($urandom);
        push("halt_hold", 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, p4, 1'b1, 1'b0);
        next_cycle();
      end
      do_reset(1);
    end
  endtask

  initial begin
    do_reset(2);
    // Directed cases from the plan.
    run_instr("add",      6'b000000, 32'h0000_0000, 32'h0, 1'b0, 1'b0, 26'h0, 32'h0, -1);
    run_instr("lw",       6'b100111, 32'h0000_0010, 32'h0, 1'b0, 1'b0, 26'h0, 32'h0, -1);
    run_instr("sw",       6'b100110, 32'h0000_0014, 32'h0, 1'b0, 1'b0, 26'h0, 32'h0, -1);
    run_instr("beq_t",    6'b110000, 32'h0000_0020, 32'hFFFF_FFFE, 1'b1, 1'b0, 26'h0, 32'h0, -1);
    run_instr("beq_nt",   6'b110000, 32'h0000_0020, 32'hFFFF_FFFE, 1'b0, 1'b0, 26'h0, 32'h0, -1);
    run_instr("bltz_t",   6'b110010, 32'h0000_0020, 32'h0000_0003, 1'b0, 1'b1, 26'h0, 32'h0, -1);
    run_instr("bne_t",    6'b110001, 32'h0000_0040, 32'h0000_0010, 1'b0, 1'b0, 26'h0, 32'h0, -1);
    run_instr("j",        6'b111000, 32'hF000_0004, 32'h0, 1'b0, 1'b0, 26'h0000040, 32'h0, -1);
    run_instr("jal",      6'b111010, 32'hF000_0004, 32'h0, 1'b0, 1'b0, 26'h0000040, 32'h0, -1);
    run_instr("jr",       6'b111001, 32'h0000_0100, 32'h0, 1'b0, 1'b0, 26'h0, 32'h0000_0048, -1);
    run_instr("illegal",  6'b101010, 32'h0000_0050, 32'h0, 1'b0, 1'b0, 26'h0, 32'h0, -1);
    run_instr("after_il", 6'b010000, 32'h0000_0054, 32'h0, 1'b0, 1'b0, 26'h0, 32'h0, -1);
    run_instr("halt",     6'b111111, 32'h0000_0058, 32'h0, 1'b0, 1'b0, 26'h0, 32'h0, -1);
    run_instr("post_hlt", 6'b000001, 32'h0000_0000, 32'h0, 1'b0, 1'b0, 26'h0, 32'h0, -1);
    run_instr("rst_exe",  6'b000000, 32'h0000_0004, 32'h0, 1'b0, 1'b0, 26'h0, 32'h0, 2);
    run_instr("rst_wb",   6'b011000, 32'h0000_0008, 32'h0, 1'b0, 1'b0, 26'h0, 32'h0, 3);
    run_instr("post_rst", 6'b000010, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0, 26'h0, 32'h0, -1);
    // Random instructions, some undefined opcodes, occasional aborts.
    for (int i = 0; i < 300; i++) begin
      logic [5:0] op;
      int ab;
      if ($urandom_range(0, 4) == 0) op = 6'($urandom);
      else op = legal_ops[$urandom_range(0, 14)];
      ab = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 4) : -1;
      run_instr("rand", op, $urandom, $urandom, 1'($urandom), 1'($urandom),
                26'($urandom), $urandom, ab);
    end
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expected records left unchecked, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
